// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding and bill values for the vending machine
package vending_pkg;
  typedef enum logic [1:0] {IDLE, VEND, CHG1, CHG5} state_t;
  localparam int BILL1  = 1;
  localparam int BILL5  = 5;
  localparam int BILL10 = 10;
endpackage

// File: rtl/vending_param_if.sv
// vending_param_if: bill acceptor inputs and dispenser/changer outputs
interface vending_param_if #(parameter int CW = 4);
  logic m1, m5, m10, cancel;
  logic open, c1, c5, busy;
  logic [CW-1:0] credit;
  modport master (output m1, m5, m10, cancel, input open, c1, c5, busy, credit);
  modport slave (input m1, m5, m10, cancel, output open, c1, c5, busy, credit);
endinterface

// File: rtl/vending_change_split.sv
// vending_change_split: splits an amount into 1k/5k bill counts
module vending_change_split #(
  parameter int CW = 4,
  parameter bit C5_EN = 1'b1
) (
  input  logic [CW-1:0] change,
  output logic [CW-1:0] n1,
  output logic [CW-1:0] n5
);
  assign n5 = C5_EN ? change / CW'(5) : '0;
  assign n1 = C5_EN ? change % CW'(5) : change;
endmodule

// File: rtl/vending_param.sv
// vending_param: Moore vending FSM with parametrised price, refund and change pay-out
module vending_param
  import vending_pkg::*;
#(
  parameter int PRICE = 2,
  parameter bit C5_EN = 1'b1,
  localparam int CW = $clog2(PRICE + 10)
) (
  input logic clk,
  input logic reset,
  vending_param_if.slave bus
);
  state_t state, state_n;
  logic [CW-1:0] credit, credit_n, n1, n1_n, n5, n5_n;
  logic [CW-1:0] bill, sum, change, s1, s5;
  logic one_hot, refund;
  assign one_hot = ({1'b0, bus.m1} + {1'b0, bus.m5} + {1'b0, bus.m10}) == 2'd1;
  assign bill = !one_hot ? '0 : bus.m1 ? CW'(BILL1) : bus.m5 ? CW'(BILL5) : CW'(BILL10);
  assign sum = credit + bill;
  assign refund = bus.cancel && credit != '0;
  // one splitter serves both the refund and the post-vend change
  assign change = bus.cancel ? credit : sum - CW'(PRICE);
  vending_change_split #(.CW(CW), .C5_EN(C5_EN)) u_split (
    .change(change),
    .n1(s1),
    .n5(s5)
  );
  always_comb begin
    state_n = state;
    credit_n = credit;
    n1_n = n1;
    n5_n = n5;
    case (state)
      IDLE: begin
        if (refund) begin
          state_n = s1 != '0 ? CHG1 : CHG5;
          credit_n = '0;
          n1_n = s1;
          n5_n = s5;
        end else if (!bus.cancel) begin
          if (sum >= CW'(PRICE)) begin
            state_n = VEND;
            credit_n = '0;
            n1_n = s1;
            n5_n = s5;
          end else credit_n = sum;
        end
      end
      VEND: state_n = n1 != '0 ? CHG1 : n5 != '0 ? CHG5 : IDLE;
      CHG1: begin
        n1_n = n1 - 1'b1;
        if (n1 == CW'(1)) state_n = n5 != '0 ? CHG5 : IDLE;
      end
      CHG5: begin
        n5_n = n5 - 1'b1;
        if (n5 == CW'(1)) state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      credit <= '0;
      n1 <= '0;
      n5 <= '0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      n1 <= n1_n;
      n5 <= n5_n;
    end
  end
  assign bus.open = state == VEND;
  assign bus.c1 = state == CHG1;
  assign bus.c5 = state == CHG5;
  assign bus.busy = state != IDLE;
  assign bus.credit = credit;
endmodule

// File: tb/tb_vending_param.sv
// tb_vending_param: three price/mode variants checked cycle by cycle against an output-queue model
module tb_vending_param;
  localparam int CW0 = $clog2(2 + 10);
  localparam int CW2 = $clog2(7 + 10);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m1 = 1'b0, m5 = 1'b0, m10 = 1'b0, cancel = 1'b0;
  int checks = 0, errors = 0;
  vending_param_if #(.CW(CW0)) b0 ();
  vending_param_if #(.CW(CW0)) b1 ();
  vending_param_if #(.CW(CW2)) b2 ();
  assign {b0.m1, b0.m5, b0.m10, b0.cancel} = {m1, m5, m10, cancel};
  assign {b1.m1, b1.m5, b1.m10, b1.cancel} = {m1, m5, m10, cancel};
  assign {b2.m1, b2.m5, b2.m10, b2.cancel} = {m1, m5, m10, cancel};
  vending_param #(.PRICE(2), .C5_EN(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  vending_param #(.PRICE(2), .C5_EN(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(b1));
  vending_param #(.PRICE(7), .C5_EN(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(b2));
  always #5 clk = ~clk;
  // each machine is modelled as credit plus a queue of upcoming output cycles
  localparam int OPEN = 100;
  int price [3] = '{2, 2, 7};
  bit c5en [3] = '{1'b1, 1'b0, 1'b1};
  int cred [3];
  int seq [3][256];
  int hd [3];
  int tl [3];
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void push(int i, int v);
    seq[i][tl[i]] = v;
    tl[i]++;
  endfunction
  function automatic void pay(int i, int amount);
    int k5 = c5en[i] ? amount / 5 : 0;
    for (int k = 0; k < amount - 5 * k5; k++) push(i, 1);
    for (int k = 0; k < k5; k++) push(i, 5);
  endfunction
  function automatic void clear(int i);
    cred[i] = 0;
    hd[i] = 0;
    tl[i] = 0;
  endfunction
  function automatic void step(int i);
    if (reset) clear(i);
    else if (hd[i] != tl[i]) begin
      hd[i]++;
      if (hd[i] == tl[i]) begin
        hd[i] = 0;
        tl[i] = 0;
      end
    end else if (cancel) begin
      if (cred[i] > 0) pay(i, cred[i]);
      cred[i] = 0;
    end else if (int'(m1) + int'(m5) + int'(m10) == 1) begin
      cred[i] += m1 ? 1 : m5 ? 5 : 10;
      if (cred[i] >= price[i]) begin
        push(i, OPEN);
        pay(i, cred[i] - price[i]);
        cred[i] = 0;
      end
    end
  endfunction
  function automatic int dut_flags(int i);
    case (i)
      0: return int'({b0.open, b0.c1, b0.c5, b0.busy});
      1: return int'({b1.open, b1.c1, b1.c5, b1.busy});
      default: return int'({b2.open, b2.c1, b2.c5, b2.busy});
    endcase
  endfunction
  function automatic int dut_credit(int i);
    case (i)
      0: return int'(b0.credit);
      1: return int'(b1.credit);
      default: return int'(b2.credit);
    endcase
  endfunction
  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      int f = hd[i] != tl[i] ? seq[i][hd[i]] : 0;
      check($sformatf("i%0d_flags", i), dut_flags(i),
            int'({f == OPEN, f == 1, f == 5, hd[i] != tl[i]}));
      check($sformatf("i%0d_credit", i), dut_credit(i), cred[i]);
    end
  endtask
  task automatic cycle(input logic a1, input logic a5, input logic a10, input logic ac);
    {m1, m5, m10, cancel} = {a1, a5, a10, ac};
    @(posedge clk);
    for (int i = 0; i < 3; i++) step(i);
    @(negedge clk);
    compare_all();
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) clear(i);
    idle(2);
    reset = 1'b0;
    idle(1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(12);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(10);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    idle(8);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(12);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    reset = 1'b1;
    #1;
    check("async_rst_flags0", dut_flags(0), 0);
    check("async_rst_flags1", dut_flags(1), 0);
    check("async_rst_flags2", dut_flags(2), 0);
    for (int i = 0; i < 3; i++) clear(i);
    idle(1);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int n = 0; n < 4000; n++) begin
      int r = int'($urandom_range(0, 15));
      reset = $urandom_range(0, 299) == 0;
      cycle(r == 0 || r == 4, r == 1 || r == 4, r == 2, r == 3);
      reset = 1'b0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vending_param.md
# vending_param

Parametrised successor of the team's fixed-price cola machine: a single-clock Moore FSM that accumulates 1k/5k/10k-won bill pulses, vends once credit reaches `PRICE`, and pays change one bill per clock in the order open -> c1 -> c5. It adds a cancel/refund path, a `busy` back-pressure flag for the bill acceptor, and a mode parameter for change composition. It sits between the bill-acceptor pulse logic and the dispenser/changer actuators.

## Interface
- `PRICE`, 2, item price in 1000-won units; legal 1..31
- `C5_EN`, 1, 1 = pay change greedily with 5k bills; 0 = pay all change in 1k bills
- `CW`, derived `$clog2(PRICE+10)`, credit/change width (not user-set)
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `m1`  in  1  1k-won bill inserted (one-cycle pulse)
- `m5`  in  1  5k-won bill inserted
- `m10`  in  1  10k-won bill inserted
- `cancel`  in  1  refund request (one-cycle pulse)
- `open`  out  1  dispense item
- `c1`  out  1  eject one 1k bill this cycle
- `c5`  out  1  eject one 5k bill this cycle
- `busy`  out  1  FSM not in IDLE; acceptor must hold bills
- `credit`  out  CW  current accumulated credit (1000-won units)

## Operation
- States: IDLE, VEND, CHG1, CHG5. Outputs decoded from registered state only (Moore); `busy` = state != IDLE.
- IDLE: exactly one of m1/m5/m10 high -> credit += 1/5/10. Zero or >1 bill inputs high -> no change (multi-hot discarded).
- If updated credit >= PRICE: change = credit - PRICE, split into n5/n1, next state VEND, credit register cleared.
- Split: C5_EN=1 -> n5 = change/5, n1 = change%5; C5_EN=0 -> n5 = 0, n1 = change.
- VEND: open=1 for one cycle; next CHG1 if n1>0, else CHG5 if n5>0, else IDLE.
- CHG1: c1=1 each cycle, n1 decrements; at n1==1 leave to CHG5 (n5>0) or IDLE.
- CHG5: c5=1 each cycle, n5 decrements; at n5==1 go to IDLE.
- cancel in IDLE with credit>0: refund credit via the same split, skipping VEND (next CHG1 or CHG5). cancel with credit 0: no effect. cancel beats a same-cycle bill (bill ignored).
- Outside IDLE, m1/m5/m10/cancel ignored; credit holds 0.
- Max credit before vend = PRICE-1+10, fits CW; no overflow possible.
- At most one of open/c1/c5 high in any cycle.

## Timing
- Reset values: state IDLE, credit 0, n1=n5=0, open=c1=c5=busy=0.
- Bill sampled at edge k reaching PRICE -> open high in cycle k+1, first change bill in k+2.
- Total busy cycles per vend = 1 + n1 + n5; per refund = n1 + n5.
- Reset asserted mid-dispense: outputs drop asynchronously, pending change lost (abort, no resumption).
- Back-to-back: bill accepted in the first IDLE cycle after dispense completes.

## Structure
- Package `vending_pkg`: state enum (IDLE/VEND/CHG1/CHG5), bill value constants (1, 5, 10).
- Sub-module `vending_change_split`: combinational change -> {n1, n5} per C5_EN; instantiated once, shared by vend and refund paths.
- Top holds state register, credit register, n1/n5 down-counters.

## Test plan
- PRICE=2: m1, m1 -> open one cycle after second pulse, no c1/c5, back to IDLE, credit 0.
- PRICE=2, C5_EN=1: m10 -> open, c1,c1,c1, c5 (5 busy cycles), then IDLE.
- PRICE=2, C5_EN=0: m10 -> open then 8 consecutive c1 pulses, c5 never high.
- PRICE=7: m5, m1, cancel -> no open, c1 x1, c5 x1, credit 0; cancel with credit 0 -> no output.
- m1 and m5 high same cycle -> credit unchanged; bill pulse during CHG1 -> ignored, change count unchanged.
- PRICE=2, m10 then reset during second c1 -> all outputs 0 immediately, IDLE, credit 0; following m1,m1 vends normally.
